vga_draw_arbiter: RTL and testbench
===================================

// Module: vga_draw_arbiter
// PURPOSE
// N-channel, parametrised arbiter between draw sources (towers, cars, lasers, screens) and the single VGA/map-memory write port.
// Grants whole bursts with a req/grant/last handshake, so one sprite or erase sequence is never interleaved with another.
// Fixed-priority or round-robin mode. Registered VGA/memory outputs.
// Built-in programmable frame-tick generator that paces animated sources.
// PARAMETERS
// NUM_CH     4        number of draw channels (2..8); channel 0 = highest fixed priority
// COLOUR_W   9        colour width
// COORD_W    15       packed coordinate width
// ADDR_W     15       map-memory address width
// RR_MODE    0        0 = fixed priority, 1 = round-robin
// MAX_BURST  19200    max beats per grant before forced release (0 = unlimited)
// TICK_DIV   1666667  enabled clk cycles per frame_tick (30 Hz at 50 MHz); must be >= 2
// TICK_W     21       width of tick counter; must hold TICK_DIV-1
// PORTS
// clk              in   1                   system clock, all logic on rising edge
// resetn           in   1                   asynchronous active-low reset
// req              in   NUM_CH              per-channel write request (beat valid)
// last             in   NUM_CH              final beat of burst, qualified by req&grant
// colour_in        in   NUM_CH*COLOUR_W     flattened colours, channel k at [k*COLOUR_W +: COLOUR_W]
// coord_in         in   NUM_CH*COORD_W      flattened coordinates, same packing
// addr_in          in   NUM_CH*ADDR_W       flattened map addresses, same packing
// tick_enable      in   1                   frame counter runs only when high
// grant            out  NUM_CH              one-hot grant, registered
// busy             out  1                   high while any grant is held
// active_ch        out  $clog2(NUM_CH)      index of granted or last-granted channel
// colour           out  COLOUR_W            registered VGA colour
// coordinates      out  COORD_W             registered VGA coordinate
// mem_add          out  ADDR_W              registered map-memory address
// VGA_write_enable out  1                   registered write strobe
// frame_tick       out  1                   one-cycle pulse every TICK_DIV enabled cycles
// BEHAVIOUR
// - Reset (async, any state): all outputs 0; FSM goes to IDLE; RR pointer = 0; beat and tick counters = 0.
// - FSM IDLE: if req != 0 at edge t, winner is latched. grant[winner] = 1 and busy = 1 from t+1. FSM goes to BURST.
// - Fixed mode: the lowest set req index wins.
// - RR mode: the first set req at or after the pointer (cyclic) wins.
// - FSM BURST: a beat is any cycle with req[k] & grant[k].
// - Beat at edge t: colour/coordinates/mem_add = channel k data and VGA_write_enable = 1 at t+1 (1-cycle latency).
// - Cycle with no beat (req[k] low): VGA_write_enable = 0 next cycle; grant held (stall); data outputs hold their last value.
// - Release occurs on a beat with last[k] = 1, or on the beat that makes the beat count equal MAX_BURST (forced release, MAX_BURST != 0).
// - On release at edge t:
//   - the final beat is still written at t+1;
//   - grant = 0 and busy = 0 at t+1;
//   - FSM returns to IDLE;
//   - the RR pointer becomes (k+1) mod NUM_CH;
//   - the beat counter clears.
// - Earliest next grant is at t+2: one idle cycle between bursts.
// - Requests from ungranted channels are ignored; no pre-emption. The beat counter is wide enough for MAX_BURST.
// - last without req, or on an ungranted channel, is ignored.
// - active_ch updates with grant and holds after release.
// - Frame tick: when tick_enable = 1, counter increments each cycle.
//   - At count TICK_DIV-1 it wraps to 0 and frame_tick = 1 on the following cycle only.
//   - When tick_enable = 0, the counter holds and frame_tick = 0.
//   - The tick is independent of the arbiter FSM.
// TESTING
// 1. Fixed mode, req=4'b0110 simultaneously -> grant=4'b0010 one cycle later. 3 beats with last on 3rd -> 3 writes of ch1 data, grant=0 next cycle, ch2 granted the cycle after.
// 2. RR mode, ch1 burst ends, then req=4'b0110 -> grant=4'b0100 (pointer=2). Next arbitration with req=4'b0011 -> ch0 via wrap.
// 3. Stall: granted ch3 drops req for 2 cycles mid-burst -> VGA_write_enable=0 for 2 cycles, grant stays 4'b1000, no other channel granted.
// 4. MAX_BURST=4, ch0 holds req with last=0 -> exactly 4 writes, forced release, pending ch1 granted 2 cycles after the 4th beat.
// 5. TICK_DIV=5, tick_enable high 12 cycles then low 3 then high -> frame_tick after enabled cycles 5 and 10; no tick while low; next tick after 5 more enabled cycles.
// 6. Assert resetn=0 asynchronously mid-burst -> grant, busy, VGA_write_enable, colour, coordinates, mem_add, frame_tick all 0 immediately; fresh arbitration from IDLE after release.

Source files
------------

// File: rtl/vga_draw_arbiter.sv
// Burst arbiter between N draw sources and the single VGA/map-memory write port,
// plus a programmable frame-tick generator used to pace animated sources.
module vga_draw_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int COLOUR_W  = 9,
  parameter int COORD_W   = 15,
  parameter int ADDR_W    = 15,
  parameter int RR_MODE   = 0,
  parameter int MAX_BURST = 19200,
  parameter int TICK_DIV  = 1666667,
  parameter int TICK_W    = 21,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH-1:0]            last,
  input  logic [NUM_CH*COLOUR_W-1:0]   colour_in,
  input  logic [NUM_CH*COORD_W-1:0]    coord_in,
  input  logic [NUM_CH*ADDR_W-1:0]     addr_in,
  input  logic                         tick_enable,
  output logic [NUM_CH-1:0]            grant,
  output logic                         busy,
  output logic [CH_W-1:0]              active_ch,
  output logic [COLOUR_W-1:0]          colour,
  output logic [COORD_W-1:0]           coordinates,
  output logic [ADDR_W-1:0]            mem_add,
  output logic                         VGA_write_enable,
  output logic                         frame_tick
);

  localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e                state_q, state_d;
  logic [NUM_CH-1:0]     grant_q, grant_d;
  logic [CH_W-1:0]       active_ch_q, active_ch_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [COLOUR_W-1:0]   colour_q, colour_d;
  logic [COORD_W-1:0]    coord_q, coord_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  we_q, we_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [CH_W-1:0]       winner;

  logic [COLOUR_W-1:0]   colour_arr [NUM_CH];
  logic [COORD_W-1:0]    coord_arr  [NUM_CH];
  logic [ADDR_W-1:0]     addr_arr   [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign colour_arr[k] = colour_in[k*COLOUR_W +: COLOUR_W];
    assign coord_arr[k]  = coord_in[k*COORD_W +: COORD_W];
    assign addr_arr[k]   = addr_in[k*ADDR_W +: ADDR_W];
  end

  // Fixed mode scans from channel 0; round-robin scans cyclically from the pointer.
  always_comb begin : pick_winner
    int  idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (RR_MODE != 0) ? (int'(rr_ptr_q) + i) % NUM_CH : i;
      if (!found && req[CH_W'(idx)]) begin
        winner = CH_W'(idx);
        found  = 1'b1;
      end
    end
  end

  // NOTE: every signal gets a default at the top of the block so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    active_ch_d = active_ch_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    colour_d    = colour_q;
    coord_d     = coord_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d         = S_BURST;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          active_ch_d     = winner;
          beat_cnt_d      = '0;
        end
      end
      S_BURST: begin
        if (req[active_ch_q]) begin
          we_d       = 1'b1;
          colour_d   = colour_arr[active_ch_q];
          coord_d    = coord_arr[active_ch_q];
          addr_d     = addr_arr[active_ch_q];
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          // Release on an explicit last or when this beat reaches the burst cap.
          if (last[active_ch_q] ||
              ((MAX_BURST != 0) && (beat_cnt_q == BEAT_W'(MAX_BURST - 1)))) begin
            state_d    = S_IDLE;
            grant_d    = '0;
            beat_cnt_d = '0;
            rr_ptr_d   = (active_ch_q == CH_W'(NUM_CH - 1)) ? '0
                                                            : active_ch_q + CH_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tick_cnt_d   = tick_cnt_q;
    frame_tick_d = 1'b0;
    if (tick_enable) begin
      if (tick_cnt_q == TICK_W'(TICK_DIV - 1)) begin
        tick_cnt_d   = '0;
        frame_tick_d = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + TICK_W'(1);
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the values
  // from before the edge; reset is asynchronous and clears all outputs at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      active_ch_q  <= '0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      colour_q     <= '0;
      coord_q      <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      tick_cnt_q   <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      active_ch_q  <= active_ch_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      colour_q     <= colour_d;
      coord_q      <= coord_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      tick_cnt_q   <= tick_cnt_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign grant            = grant_q;
  assign busy             = (state_q == S_BURST);
  assign active_ch        = active_ch_q;
  assign colour           = colour_q;
  assign coordinates      = coord_q;
  assign mem_add          = addr_q;
  assign VGA_write_enable = we_q;
  assign frame_tick       = frame_tick_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench: a fixed-priority instance (MAX_BURST=4) and a round-robin instance
// (unlimited bursts) share stimulus; both use TICK_DIV=5.
module tb_vga_draw_arbiter;

  logic        clk;
  logic        resetn;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [35:0] colour_in;
  logic [59:0] coord_in;
  logic [59:0] addr_in;
  logic        tick_enable;

  logic [3:0]  grant_f, grant_r;
  logic        busy_f, busy_r;
  logic [1:0]  ach_f, ach_r;
  logic [8:0]  col_f, col_r;
  logic [14:0] crd_f, crd_r;
  logic [14:0] add_f, add_r;
  logic        we_f, we_r;
  logic        ft_f, ft_r;

  int checks = 0;
  int errors = 0;

  vga_draw_arbiter #(.NUM_CH(4), .COLOUR_W(9), .COORD_W(15), .ADDR_W(15), .RR_MODE(0),
                     .MAX_BURST(4), .TICK_DIV(5), .TICK_W(3)) dut_f (
    .clk(clk), .resetn(resetn), .req(req), .last(last), .colour_in(colour_in),
    .coord_in(coord_in), .addr_in(addr_in), .tick_enable(tick_enable),
    .grant(grant_f), .busy(busy_f), .active_ch(ach_f), .colour(col_f),
    .coordinates(crd_f), .mem_add(add_f), .VGA_write_enable(we_f), .frame_tick(ft_f));

  vga_draw_arbiter #(.NUM_CH(4), .COLOUR_W(9), .COORD_W(15), .ADDR_W(15), .RR_MODE(1),
                     .MAX_BURST(0), .TICK_DIV(5), .TICK_W(3)) dut_r (
    .clk(clk), .resetn(resetn), .req(req), .last(last), .colour_in(colour_in),
    .coord_in(coord_in), .addr_in(addr_in), .tick_enable(tick_enable),
    .grant(grant_r), .busy(busy_r), .active_ch(ach_r), .colour(col_r),
    .coordinates(crd_r), .mem_add(add_r), .VGA_write_enable(we_r), .frame_tick(ft_r));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    resetn = 1'b0; req = '0; last = '0; tick_enable = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic set_ch(input int k, input logic [8:0] c, input logic [14:0] co,
                        input logic [14:0] a);
    colour_in[k*9 +: 9]  = c;
    coord_in[k*15 +: 15] = co;
    addr_in[k*15 +: 15]  = a;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (grant_f !== 4'b0000 || grant_r !== 4'b0000) begin errors++;
      $display("FAIL reset_grant got %b/%b exp 0000", grant_f, grant_r); end
    checks++; if (busy_f !== 1'b0 || we_f !== 1'b0 || ft_f !== 1'b0 || ach_f !== 2'd0) begin errors++;
      $display("FAIL reset_ctrl got busy %b we %b ft %b ach %0d exp 0", busy_f, we_f, ft_f, ach_f); end
    checks++; if (col_f !== 9'h0 || crd_f !== 15'h0 || add_f !== 15'h0) begin errors++;
      $display("FAIL reset_data got %h %h %h exp 0", col_f, crd_f, add_f); end
  endtask

  task automatic test_fixed_priority();
    logic [8:0] ec;
    do_reset();
    set_ch(2, 9'h022, 15'h0222, 15'h2222);
    req = 4'b0110; last = 4'b0000;
    step();
    checks++; if (grant_f !== 4'b0010 || busy_f !== 1'b1 || ach_f !== 2'd1) begin errors++;
      $display("FAIL fix_grant got %b busy %b ach %0d exp 0010 1 1", grant_f, busy_f, ach_f); end
    checks++; if (we_f !== 1'b0) begin errors++;
      $display("FAIL fix_grant_we got %b exp 0", we_f); end
    for (int b = 1; b <= 3; b++) begin
      ec = 9'h010 + 9'(b);
      set_ch(1, ec, 15'h0100 + 15'(b), 15'h1000 + 15'(b));
      last = (b == 3) ? 4'b0010 : 4'b0000;
      step();
      checks++; if (we_f !== 1'b1 || col_f !== ec || crd_f !== 15'h0100 + 15'(b)
                    || add_f !== 15'h1000 + 15'(b)) begin errors++;
        $display("FAIL fix_beat%0d got we %b %h %h %h exp 1 %h", b, we_f, col_f, crd_f, add_f, ec); end
      checks++; if (grant_f !== ((b == 3) ? 4'b0000 : 4'b0010)) begin errors++;
        $display("FAIL fix_beat%0d_grant got %b", b, grant_f); end
    end
    checks++; if (busy_f !== 1'b0 || ach_f !== 2'd1) begin errors++;
      $display("FAIL fix_release got busy %b ach %0d exp 0 1", busy_f, ach_f); end
    req = 4'b0100; last = 4'b0000;
    step();
    checks++; if (grant_f !== 4'b0100 || ach_f !== 2'd2 || we_f !== 1'b0) begin errors++;
      $display("FAIL fix_next got %b ach %0d we %b exp 0100 2 0", grant_f, ach_f, we_f); end
    checks++; if (col_f !== 9'h013) begin errors++;
      $display("FAIL fix_hold got %h exp 013", col_f); end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_ch(1, 9'h0A1, 15'h0A11, 15'h0A12);
    set_ch(2, 9'h0B2, 15'h0B21, 15'h0B22);
    set_ch(0, 9'h0C0, 15'h0C01, 15'h0C02);
    req = 4'b0010; last = 4'b0000;
    step();
    checks++; if (grant_r !== 4'b0010) begin errors++;
      $display("FAIL rr_first got %b exp 0010", grant_r); end
    last = 4'b0010;
    step();
    checks++; if (we_r !== 1'b1 || col_r !== 9'h0A1 || grant_r !== 4'b0000) begin errors++;
      $display("FAIL rr_release got we %b %h %b exp 1 0a1 0000", we_r, col_r, grant_r); end
    req = 4'b0110; last = 4'b0000;
    step();
    checks++; if (grant_r !== 4'b0100 || ach_r !== 2'd2) begin errors++;
      $display("FAIL rr_ptr2 got %b ach %0d exp 0100 2", grant_r, ach_r); end
    checks++; if (grant_f !== 4'b0010) begin errors++;
      $display("FAIL rr_fixed_contrast got %b exp 0010", grant_f); end
    last = 4'b0100;
    step();
    checks++; if (we_r !== 1'b1 || col_r !== 9'h0B2 || add_r !== 15'h0B22 || grant_r !== 4'b0000) begin errors++;
      $display("FAIL rr_ch2_beat got we %b %h %h %b", we_r, col_r, add_r, grant_r); end
    req = 4'b0011; last = 4'b0000;
    step();
    checks++; if (grant_r !== 4'b0001 || ach_r !== 2'd0) begin errors++;
      $display("FAIL rr_wrap got %b ach %0d exp 0001 0", grant_r, ach_r); end
  endtask

  task automatic test_stall();
    do_reset();
    set_ch(3, 9'h133, 15'h3333, 15'h0333);
    req = 4'b1000; last = 4'b0000;
    step();
    checks++; if (grant_f !== 4'b1000) begin errors++;
      $display("FAIL stall_grant got %b exp 1000", grant_f); end
    step();
    checks++; if (we_f !== 1'b1 || col_f !== 9'h133) begin errors++;
      $display("FAIL stall_beat1 got we %b %h exp 1 133", we_f, col_f); end
    req = 4'b0111;
    set_ch(3, 9'h1FF, 15'h7FFF, 15'h7FFF);
    for (int s = 0; s < 2; s++) begin
      step();
      checks++; if (we_f !== 1'b0 || grant_f !== 4'b1000 || col_f !== 9'h133 || busy_f !== 1'b1) begin errors++;
        $display("FAIL stall_cyc%0d got we %b grant %b col %h", s, we_f, grant_f, col_f); end
    end
    req = 4'b1000; last = 4'b1000;
    set_ch(3, 9'h144, 15'h3444, 15'h0444);
    step();
    checks++; if (we_f !== 1'b1 || col_f !== 9'h144 || add_f !== 15'h0444 || grant_f !== 4'b0000) begin errors++;
      $display("FAIL stall_last got we %b %h %h %b", we_f, col_f, add_f, grant_f); end
  endtask

  task automatic test_max_burst();
    logic [8:0] ec;
    do_reset();
    req = 4'b0011; last = 4'b0000;
    step();
    checks++; if (grant_f !== 4'b0001) begin errors++;
      $display("FAIL maxb_grant got %b exp 0001", grant_f); end
    for (int b = 1; b <= 4; b++) begin
      ec = 9'h0C0 + 9'(b);
      set_ch(0, ec, 15'h0C00 + 15'(b), 15'h4C00 + 15'(b));
      step();
      checks++; if (we_f !== 1'b1 || col_f !== ec || grant_f !== ((b < 4) ? 4'b0001 : 4'b0000)) begin errors++;
        $display("FAIL maxb_beat%0d got we %b %h grant %b", b, we_f, col_f, grant_f); end
    end
    req = 4'b0010;
    step();
    checks++; if (grant_f !== 4'b0010 || ach_f !== 2'd1 || we_f !== 1'b0) begin errors++;
      $display("FAIL maxb_next got %b ach %0d we %b exp 0010 1 0", grant_f, ach_f, we_f); end
  endtask

  task automatic test_frame_tick();
    logic exp;
    do_reset();
    tick_enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp = (i == 5 || i == 10);
      checks++; if (ft_f !== exp || ft_r !== exp) begin errors++;
        $display("FAIL tick_en%0d got %b/%b exp %b", i, ft_f, ft_r, exp); end
    end
    tick_enable = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (ft_f !== 1'b0) begin errors++;
        $display("FAIL tick_off%0d got %b exp 0", i, ft_f); end
    end
    tick_enable = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      exp = (j == 3);
      checks++; if (ft_f !== exp) begin errors++;
        $display("FAIL tick_resume%0d got %b exp %b", j, ft_f, exp); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_ch(0, 9'h1AB, 15'h2BCD, 15'h3CDE);
    tick_enable = 1'b1;
    req = 4'b0001; last = 4'b0000;
    for (int i = 0; i < 5; i++) step();
    checks++; if (we_r !== 1'b1 || ft_r !== 1'b1 || col_r !== 9'h1AB || grant_r !== 4'b0001) begin errors++;
      $display("FAIL arst_pre got we %b ft %b %h %b", we_r, ft_r, col_r, grant_r); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (grant_r !== 4'b0000 || busy_r !== 1'b0 || we_r !== 1'b0 || ft_r !== 1'b0) begin errors++;
      $display("FAIL arst_ctrl got %b busy %b we %b ft %b", grant_r, busy_r, we_r, ft_r); end
    checks++; if (col_r !== 9'h0 || crd_r !== 15'h0 || add_r !== 15'h0 || ach_r !== 2'd0) begin errors++;
      $display("FAIL arst_data got %h %h %h ach %0d", col_r, crd_r, add_r, ach_r); end
    req = 4'b0100; tick_enable = 1'b0;
    #1;
    resetn = 1'b1;
    step();
    checks++; if (grant_r !== 4'b0100 || ach_r !== 2'd2 || we_r !== 1'b0) begin errors++;
      $display("FAIL arst_fresh got %b ach %0d we %b exp 0100 2 0", grant_r, ach_r, we_r); end
  endtask

  initial begin
    resetn = 1'b0; req = '0; last = '0; tick_enable = 1'b0;
    colour_in = '0; coord_in = '0; addr_in = '0;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_stall();
    test_max_burst();
    test_frame_tick();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
